uart_bus_host: RTL and testbench
================================

UART_BUS_HOST -- requirements
Module: uart_bus_host

Interface
REQ-001 SHALL have parameter ClockFrequency, default 50_000_000, system clock in Hz.
REQ-002 SHALL have parameter BaudRate, default 115_200, serial bit rate; ClocksPerBaud = ClockFrequency / BaudRate.
REQ-003 SHALL have parameter AddrWidth, default 32, bus address width.
REQ-004 SHALL have parameter DataWidth, default 32, bus data width.
REQ-005 SHALL have parameter TimeoutBits, default 160, inter-byte timeout in bit periods; used only with the timeout feature.
REQ-006 SHALL have ports, one per line:
- clk_i  in  1  sole clock.
- rst_i  in  1  asynchronous, active-high reset.
- uart_rx_i  in  1  serial command input, asynchronous to clk_i.
- uart_tx_o  out  1  serial response output.
- host_req_o  out  1  bus request.
- host_gnt_i  in  1  bus grant.
- host_addr_o  out  AddrWidth  bus address.
- host_we_o  out  1  1 = write.
- host_be_o  out  4  byte enables.
- host_wdata_o  out  DataWidth  write data.
- host_rvalid_i  in  1  response valid, for reads and writes.
- host_rdata_i  in  DataWidth  read data.
- busy_o  out  1  frame in progress.

Function
REQ-007 SHALL synchronise uart_rx_i through 2 flops and treat a 1->0 edge in RX_IDLE as a start bit.
REQ-008 SHALL sample each bit at ClocksPerBaud/2 after the start edge, then every ClocksPerBaud clocks, LSB first, 8N1.
REQ-009 SHALL re-check the start bit at mid-bit and return to RX_IDLE without a byte if it reads 1.
REQ-010 SHALL discard a byte whose stop bit samples 0 (framing error), without changing frame state.
REQ-011 Frame FSM states SHALL be CMD, ADDR, WDATA, BUS_REQ, BUS_WAIT, RESP.
REQ-012 In CMD: 0x57 ('W') SHALL select write, 0x52 ('R') read; any other byte SHALL be ignored.
REQ-013 ADDR SHALL collect 4 bytes little-endian, then go to WDATA for writes or BUS_REQ for reads.
REQ-014 WDATA SHALL collect 4 bytes little-endian, then go to BUS_REQ.
REQ-015 BUS_REQ SHALL hold host_req_o=1, host_be_o=4'hF, and keep addr/we/wdata stable until host_gnt_i=1 is sampled.
REQ-016 host_req_o SHALL deassert in the cycle after the grant.
REQ-017 BUS_WAIT SHALL wait for host_rvalid_i; an rvalid in the grant cycle itself SHALL also be accepted.
REQ-018 On rvalid, a read SHALL capture host_rdata_i.
REQ-019 RESP for a write SHALL transmit the single byte 0x4B ('K'); for a read it SHALL transmit 4 data bytes, LSB byte first.
REQ-020 After the last response stop bit, the FSM SHALL return to CMD; bytes received during BUS_REQ, BUS_WAIT or RESP SHALL be dropped.
REQ-021 TX SHALL send start(0), 8 data bits LSB first, stop(1), each ClocksPerBaud clocks, back-to-back with no idle gap between response bytes.
REQ-022 uart_tx_o SHALL be 1 when idle.
REQ-023 busy_o SHALL be 1 in every state except CMD.
REQ-024 Baud counters SHALL be $clog2(ClocksPerBaud) bits wide and wrap to 0 at ClocksPerBaud-1.

Reset
REQ-025 While rst_i=1: uart_tx_o=1, host_req_o=0, host_we_o=0, host_be_o=0, host_addr_o=0, host_wdata_o=0, busy_o=0, FSM=CMD, RX=RX_IDLE, counters=0.
REQ-026 Reset asserted mid-frame or mid-transaction SHALL abandon it with no response byte; after release the next valid command SHALL be accepted.

Configuration
REQ-027 With UART_BUS_HOST_TIMEOUT_EN defined: in ADDR or WDATA, TimeoutBits bit periods without a received byte SHALL abort to CMD and transmit 0x45 ('E').
REQ-028 With UART_BUS_HOST_TIMEOUT_EN defined: in BUS_REQ or BUS_WAIT, the same timeout SHALL deassert host_req_o, abort, and transmit 0x45.
REQ-029 Without UART_BUS_HOST_TIMEOUT_EN, the block SHALL wait indefinitely and SHALL contain no timeout logic.

Structure
REQ-030 Package uart_bus_host_pkg SHALL hold the command/response byte constants (0x57, 0x52, 0x4B, 0x45) and the frame-state enum.
REQ-031 The receive bit engine SHALL be the sub-module uart_byte_rx, outputs byte[7:0] and a 1-cycle byte_valid strobe.

Verification
REQ-032 Scenario write: serial 57 10 00 00 80 EF BE AD DE -> one req with addr 0x80000010, we=1, wdata 0xDEADBEEF, be F; after rvalid, TX byte 4B.
REQ-033 Scenario read: 52 04 00 00 80, rdata 0x12345678 -> TX bytes 78 56 34 12, no idle gap between them.
REQ-034 Scenario grant stall: host_gnt_i held low 50 cycles -> req/addr stable throughout; exactly one transaction after grant.
REQ-035 Scenario noise: byte 0x00, then bytes with stop bit 0, then 52 + address -> only the read executes.
REQ-036 Scenario reset: rst_i pulse after 3 address bytes -> outputs at reset values, no TX; a following full write completes normally.
REQ-037 Scenario timeout (macro on): 57 + 2 bytes then silence -> TX 45 after 160 bit times, busy_o=0, host_req_o never asserted.

Source files
------------

// File: rtl/uart_bus_host_pkg.sv
// Shared constants and state encodings for the UART bus host.
package uart_bus_host_pkg;

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RespOk   = 8'h4B;
  localparam logic [7:0] RespErr  = 8'h45;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_BUS_REQ,
    ST_BUS_WAIT,
    ST_RESP
  } frame_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Baud counter width; never zero so a degenerate divider still elaborates.
  function automatic int unsigned cnt_width(input int unsigned clocks);
    return (clocks > 1) ? $clog2(clocks) : 1;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 receive engine: 2-flop synchroniser, mid-bit sampling, 1-cycle byte strobe.
module uart_byte_rx
  import uart_bus_host_pkg::*;
#(
  parameter int unsigned ClocksPerBaud = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o
);

  localparam int unsigned      CntW    = cnt_width(ClocksPerBaud);
  localparam logic [CntW-1:0] CntLast = CntW'(ClocksPerBaud - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClocksPerBaud / 2 - 1);

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = RX_START;
      end
      // A start bit that reads high at mid-bit was a glitch.
      RX_START: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

endmodule

// File: rtl/uart_bus_host.sv
// UART command bridge: 'W'/'R' serial frames drive one bus transaction and return 'K' or read data.
// Defining UART_BUS_HOST_TIMEOUT_EN adds an inter-byte / bus timeout that aborts with 'E'.
module uart_bus_host
  import uart_bus_host_pkg::*;
#(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned TimeoutBits    = 160
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 uart_rx_i,
  output logic                 uart_tx_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [DataWidth-1:0] host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  output logic                 busy_o
);

  localparam int unsigned      ClocksPerBaud = ClockFrequency / BaudRate;
  localparam int unsigned      CntW          = cnt_width(ClocksPerBaud);
  localparam logic [CntW-1:0] CntLast       = CntW'(ClocksPerBaud - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;

  uart_byte_rx #(
    .ClocksPerBaud(ClocksPerBaud)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_i        (uart_rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid)
  );

  frame_state_e         state_q, state_d;
  logic                 is_write_q, is_write_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [31:0]          collect_q, collect_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic [3:0]           be_q, be_d;
  logic                 req_q, req_d;
  logic                 busy_q, busy_d;
  logic [23:0]          resp_sr_q, resp_sr_d;
  logic [1:0]           resp_left_q, resp_left_d;

  logic                 tx_active_q, tx_active_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [9:0]           tx_sr_q, tx_sr_d;
  logic                 tx_q, tx_d;

  logic                 tx_load_c;
  logic [7:0]           tx_byte_c;
  logic                 tx_done_c;
  logic                 abort_c;
  logic [31:0]          rx_word_c;
  logic [31:0]          rdata_word_c;

  assign rx_word_c    = {rx_byte, collect_q[31:8]};
  assign rdata_word_c = 32'(host_rdata_i);
  assign tx_done_c    = tx_active_q && (tx_cnt_q == CntLast) && (tx_bit_q == 4'd9);

  assign uart_tx_o    = tx_q;
  assign host_req_o   = req_q;
  assign host_addr_o  = addr_q;
  assign host_we_o    = we_q;
  assign host_be_o    = be_q;
  assign host_wdata_o = wdata_q;
  assign busy_o       = busy_q;

`ifdef UART_BUS_HOST_TIMEOUT_EN
  localparam int unsigned TimeoutClocks = TimeoutBits * ClocksPerBaud;
  localparam int unsigned ToW           = $clog2(TimeoutClocks + 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           waiting_c;

  assign waiting_c = state_q inside {ST_ADDR, ST_WDATA, ST_BUS_REQ, ST_BUS_WAIT};
  assign abort_c   = waiting_c && (to_cnt_q == ToW'(TimeoutClocks - 1));

  // Restarts on every accepted frame byte and on any state change.
  always_comb begin
    to_cnt_d = '0;
    if (waiting_c && (state_d == state_q) &&
        !(rx_valid && (state_q == ST_ADDR || state_q == ST_WDATA))) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  assign abort_c = 1'b0;
`endif

  // Frame sequencing and response scheduling.
  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    byte_cnt_d  = byte_cnt_q;
    collect_d   = collect_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_sr_d   = resp_sr_q;
    resp_left_d = resp_left_q;
    tx_load_c   = 1'b0;
    tx_byte_c   = '0;
    case (state_q)
      ST_CMD: begin
        byte_cnt_d = '0;
        if (rx_valid && rx_byte == CmdWrite) begin
          is_write_d = 1'b1;
          state_d    = ST_ADDR;
        end else if (rx_valid && rx_byte == CmdRead) begin
          is_write_d = 1'b0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          collect_d  = rx_word_c;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            addr_d  = AddrWidth'(rx_word_c);
            state_d = is_write_q ? ST_WDATA : ST_BUS_REQ;
          end
        end
      end
      ST_WDATA: begin
        if (rx_valid) begin
          collect_d  = rx_word_c;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wdata_d = DataWidth'(rx_word_c);
            state_d = ST_BUS_REQ;
          end
        end
      end
      ST_BUS_REQ, ST_BUS_WAIT: begin
        if (state_q == ST_BUS_REQ && host_gnt_i) state_d = ST_BUS_WAIT;
        // rvalid alongside the grant is accepted immediately.
        if (host_rvalid_i && (state_q == ST_BUS_WAIT || host_gnt_i)) begin
          state_d   = ST_RESP;
          tx_load_c = 1'b1;
          if (is_write_q) begin
            tx_byte_c   = RespOk;
            resp_left_d = 2'd0;
          end else begin
            tx_byte_c   = rdata_word_c[7:0];
            resp_sr_d   = rdata_word_c[31:8];
            resp_left_d = 2'd3;
          end
        end
      end
      ST_RESP: begin
        if (tx_done_c) begin
          if (resp_left_q != 2'd0) begin
            tx_load_c   = 1'b1;
            tx_byte_c   = resp_sr_q[7:0];
            resp_sr_d   = {8'h00, resp_sr_q[23:8]};
            resp_left_d = resp_left_q - 2'd1;
          end else begin
            state_d = ST_CMD;
          end
        end
      end
      default: state_d = ST_CMD;
    endcase
    if (abort_c) begin
      state_d     = ST_RESP;
      byte_cnt_d  = '0;
      tx_load_c   = 1'b1;
      tx_byte_c   = RespErr;
      resp_left_d = 2'd0;
    end
  end

  // Bus outputs are registered from the next frame state.
  always_comb begin
    req_d  = (state_d == ST_BUS_REQ);
    busy_d = (state_d != ST_CMD);
    be_d   = 4'h0;
    we_d   = 1'b0;
    if (state_d == ST_BUS_REQ || state_d == ST_BUS_WAIT) begin
      be_d = 4'hF;
      we_d = is_write_d;
    end
  end

  // Transmit shifter: a new load on the final stop clock keeps bytes back-to-back.
  always_comb begin
    tx_active_d = tx_active_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_sr_d     = tx_sr_q;
    tx_d        = tx_q;
    if (tx_load_c) begin
      tx_active_d = 1'b1;
      tx_cnt_d    = '0;
      tx_bit_d    = '0;
      tx_sr_d     = {1'b1, tx_byte_c, 1'b0};
      tx_d        = 1'b0;
    end else if (tx_active_q) begin
      if (tx_cnt_q == CntLast) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_active_d = 1'b0;
          tx_d        = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
          tx_sr_d  = {1'b1, tx_sr_q[9:1]};
          tx_d     = tx_sr_q[1];
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_CMD;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= '0;
      collect_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      resp_sr_q   <= '0;
      resp_left_q <= '0;
      tx_active_q <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_sr_q     <= '1;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      byte_cnt_q  <= byte_cnt_d;
      collect_q   <= collect_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      be_q        <= be_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      resp_sr_q   <= resp_sr_d;
      resp_left_q <= resp_left_d;
      tx_active_q <= tx_active_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_sr_q     <= tx_sr_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_host.sv
// Scoreboard bench for uart_bus_host: directed serial frames, bus responder, TX decoder.
`timescale 1ns/1ps
module tb_uart_bus_host;

  localparam int unsigned ClkFreq = 1_000_000;
  localparam int unsigned Baud    = 100_000;
  localparam int unsigned Cpb     = ClkFreq / Baud;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        chk_wdata;
  } txn_t;

  typedef struct {
    logic [7:0] b;
    logic       b2b;
  } txb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        host_req;
  logic        host_gnt = 1'b0;
  logic [31:0] host_addr;
  logic        host_we;
  logic [3:0]  host_be;
  logic [31:0] host_wdata;
  logic        host_rvalid = 1'b0;
  logic [31:0] host_rdata = '0;
  logic        busy;

  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  int          gnt_delay = 1;
  int          rvalid_delay = 1;
  logic [31:0] rdata_val = '0;
  txn_t        exp_txn[$];
  txb_t        exp_tx[$];

  uart_bus_host #(
    .ClockFrequency(ClkFreq),
    .BaudRate      (Baud)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .uart_rx_i    (uart_rx),
    .uart_tx_o    (uart_tx),
    .host_req_o   (host_req),
    .host_gnt_i   (host_gnt),
    .host_addr_o  (host_addr),
    .host_we_o    (host_we),
    .host_be_o    (host_be),
    .host_wdata_o (host_wdata),
    .host_rvalid_i(host_rvalid),
    .host_rdata_i (host_rdata),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    uart_rx = stop;
    repeat (Cpb) @(negedge clk);
    uart_rx = 1'b1;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    exp_txn.push_back('{addr: a, we: 1'b1, wdata: d, chk_wdata: 1'b1});
    exp_tx.push_back('{b: 8'h4B, b2b: 1'b0});
    send_byte(8'h57, 1'b1);
    send_word(a);
    send_word(d);
  endtask

  task automatic push_read(input logic [31:0] a, input logic [31:0] rd);
    rdata_val = rd;
    exp_txn.push_back('{addr: a, we: 1'b0, wdata: 32'h0, chk_wdata: 1'b0});
    for (int i = 0; i < 4; i++) exp_tx.push_back('{b: rd[8*i +: 8], b2b: (i != 0)});
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_txn.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, 32'(n < budget), 32'd1);
    repeat (2 * Cpb) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx"},    32'(uart_tx),    32'd1);
    check({name, "_req"},   32'(host_req),   32'd0);
    check({name, "_we"},    32'(host_we),    32'd0);
    check({name, "_be"},    32'(host_be),    32'd0);
    check({name, "_addr"},  host_addr,       32'd0);
    check({name, "_wdata"}, host_wdata,      32'd0);
    check({name, "_busy"},  32'(busy),       32'd0);
  endtask

  // Bus slave: checks each request against the scoreboard, then grants and responds.
  initial begin : responder
    txn_t        t;
    logic [31:0] a0, w0;
    logic        we0, stable;
    forever begin
      @(negedge clk);
      if (!rst && host_req) begin
        if (exp_txn.size() == 0) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL unexpected_req: addr %h we %0d, required no request", host_addr, host_we);
        end else begin
          t = exp_txn.pop_front();
          check("req_addr", host_addr, t.addr);
          check("req_we", 32'(host_we), 32'(t.we));
          check("req_be", 32'(host_be), 32'hF);
          if (t.chk_wdata) check("req_wdata", host_wdata, t.wdata);
        end
        a0 = host_addr;
        w0 = host_wdata;
        we0 = host_we;
        stable = 1'b1;
        for (int i = 0; i < gnt_delay; i++) begin
          @(negedge clk);
          if (!host_req || host_addr !== a0 || host_wdata !== w0 || host_we !== we0) stable = 1'b0;
        end
        if (gnt_delay > 0) check("req_stable_during_stall", 32'(stable), 32'd1);
        host_gnt = 1'b1;
        host_rdata = rdata_val;
        if (rvalid_delay == 0) host_rvalid = 1'b1;
        @(negedge clk);
        host_gnt = 1'b0;
        host_rvalid = 1'b0;
        check("req_drop_after_gnt", 32'(host_req), 32'd0);
        if (rvalid_delay != 0) begin
          repeat (rvalid_delay - 1) @(negedge clk);
          host_rvalid = 1'b1;
          @(negedge clk);
          host_rvalid = 1'b0;
        end
      end
    end
  end

  // Serial decoder: samples each TX byte mid-bit and checks spacing of burst bytes.
  initial begin : tx_mon
    int         sc;
    int         prev_sc;
    logic [7:0] b;
    logic       start_ok;
    txb_t       e;
    prev_sc = 0;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        sc = cyc;
        repeat (Cpb / 2) @(negedge clk);
        start_ok = (uart_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (Cpb) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (Cpb) @(negedge clk);
        check("tx_start_bit", 32'(start_ok), 32'd1);
        check("tx_stop_bit", 32'(uart_tx), 32'd1);
        if (exp_tx.size() == 0) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL unexpected_tx: byte %h, required none", b);
        end else begin
          e = exp_tx.pop_front();
          check("tx_byte", 32'(b), 32'(e.b));
          if (e.b2b) check("tx_no_gap", 32'(sc - prev_sc), 32'(10 * Cpb));
        end
        prev_sc = sc;
      end
    end
  end

  initial begin : watchdog
    repeat (200_000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Write, grant after one stall cycle, rvalid one cycle later.
    gnt_delay = 1;
    rvalid_delay = 1;
    do_write(32'h8000_0010, 32'hDEAD_BEEF);
    wait_idle("write", 3000);

    // Read with rvalid in the grant cycle.
    gnt_delay = 0;
    rvalid_delay = 0;
    push_read(32'h8000_0004, 32'h1234_5678);
    send_byte(8'h52, 1'b1);
    check("busy_in_frame", 32'(busy), 32'd1);
    send_word(32'h8000_0004);
    wait_idle("read", 3000);

    // Grant withheld for 50 cycles.
    gnt_delay = 50;
    rvalid_delay = 3;
    do_write(32'h0000_0020, 32'h0102_0304);
    wait_idle("stall", 3000);

    // Noise: unknown command, framing errors, start glitch inside address.
    gnt_delay = 2;
    rvalid_delay = 2;
    send_byte(8'h00, 1'b1);
    check("noise_cmd_ignored", 32'(busy), 32'd0);
    send_byte(8'h52, 1'b0);
    check("framing_r_dropped", 32'(busy), 32'd0);
    send_byte(8'h57, 1'b0);
    check("framing_w_dropped", 32'(busy), 32'd0);
    push_read(32'h0000_0100, 32'hA5C3_0F1E);
    send_byte(8'h52, 1'b1);
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12 * Cpb) @(negedge clk);
    send_word(32'h0000_0100);
    wait_idle("noise_read", 3000);

    // Reset after three address bytes abandons the frame silently.
    send_byte(8'h57, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    check("busy_before_reset", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    repeat (20 * Cpb) @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'd0);
    gnt_delay = 1;
    rvalid_delay = 1;
    do_write(32'h0000_0040, 32'hCAFE_F00D);
    wait_idle("post_reset_write", 3000);

`ifdef UART_BUS_HOST_TIMEOUT_EN
    exp_tx.push_back('{b: 8'h45, b2b: 1'b0});
    send_byte(8'h57, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    wait_idle("timeout", 4000);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_req", 32'(host_req), 32'd0);
`endif

    repeat (5 * Cpb) @(negedge clk);
    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    check("txn_queue_drained", 32'(exp_txn.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
